fb_access_arbiter: RTL and testbench

Shares the single-port pixel frame buffer between two requesters: the VGA scanout path and the processor's pixel-write port. Scanout is served by an internal read-ahead FIFO that the arbiter fills autonomously from a sequential address counter. Processor writes are interleaved whenever the FIFO has slack. It sits between the processor write interface, the frame-buffer RAM and the hsync/vsync/RGB output stage of the console.

---
 rtl/fb_access_arbiter_pkg.sv | 32 +++
 rtl/fb_access_arbiter_if.sv | 29 ++
 rtl/fb_access_arbiter_fifo.sv | 47 ++++
 rtl/fb_access_arbiter.sv | 113 +++++++++++
 tb/tb_fb_access_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_access_arbiter_pkg.sv
// Shared constants, enums and the grant priority rule for the frame-buffer arbiter.
package fb_arb_pkg;

  localparam int ADDR_W_DEF     = 15;
  localparam int DATA_W_DEF     = 9;
  localparam int FB_WORDS_DEF   = 19200;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int HIGH_WM_DEF    = 2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_t;

  typedef enum logic [0:0] {
    SCAN_IDLE  = 1'b0,
    SCAN_FETCH = 1'b1
  } scan_state_t;

  // A starving FIFO beats the processor; otherwise the processor goes first
  // and reads take whatever slots remain.
  function automatic grant_t arb_decide(input logic rd_elig,
                                        input logic rd_urgent,
                                        input logic wr_elig);
    if (rd_elig && rd_urgent) return GNT_RD;
    if (wr_elig)              return GNT_WR;
    if (rd_elig)              return GNT_RD;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Processor write port and frame-buffer RAM port bundled as one bus.
interface fb_access_arbiter_if
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cpu_wr_valid;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: accepts processor writes, drives the RAM.
  modport master (
    input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, mem_rdata,
    output cpu_wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: the processor and the RAM.
  modport slave (
    output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, mem_rdata,
    input  cpu_wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_access_arbiter_fifo.sv
// Read-ahead pixel FIFO: flushable, exposes its occupancy; overflow
// protection is left to the producer's reservation.
module fb_pixel_fifo
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = DATA_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = store[rd_ptr];

  // Pointers and occupancy; flush empties the FIFO without touching storage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Pixel storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Frame-buffer arbiter: sequential scanout prefetch into a small FIFO,
// processor writes slotted in whenever the FIFO has slack.
module fb_access_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FB_WORDS   = FB_WORDS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int HIGH_WM    = HIGH_WM_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                frame_start,
  input  logic                pix_pop,
  output logic                pix_valid,
  output logic [DATA_W-1:0]   pix_data,
  output logic                underrun,
  output logic                scan_busy,
  fb_access_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LVL_W = CNT_W + 1;

  scan_state_t       scan_state;
  logic [ADDR_W-1:0] scan_addr;
  logic              rd_vld_p1;
  logic              rd_stale_p1;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]  level;
  logic              rd_elig;
  logic              rd_urgent;
  logic              fifo_push;
  logic              fifo_pop;
  logic              last_addr;
  grant_t            gnt;

  // A read still in flight counts as occupied so its return always has a slot.
  assign level     = LVL_W'(fifo_count) + LVL_W'(rd_vld_p1);
  assign rd_elig   = (scan_state == SCAN_FETCH) && (level < LVL_W'(FIFO_DEPTH));
  assign rd_urgent = level < LVL_W'(HIGH_WM);
  assign gnt       = reset_reset ? GNT_NONE : arb_decide(rd_elig, rd_urgent, bus.cpu_wr_valid);
  assign last_addr = scan_addr == ADDR_W'(FB_WORDS - 1);

  // Returns belonging to an older frame are dropped; frame_start flushes anyway.
  assign fifo_push = rd_vld_p1 && !rd_stale_p1 && !frame_start;
  assign fifo_pop  = pix_pop && pix_valid;

  assign pix_valid = fifo_count != '0;
  assign pix_data  = pix_valid ? fifo_head : '0;
  assign underrun  = pix_pop && !pix_valid;
  assign scan_busy = scan_state == SCAN_FETCH;

  // Drive the RAM port and the processor handshake from the grant.
  always_comb begin
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.cpu_wr_ready = 1'b0;
    case (gnt)
      GNT_RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = scan_addr;
      end
      GNT_WR: begin
        bus.mem_en       = 1'b1;
        bus.mem_we       = 1'b1;
        bus.mem_addr     = bus.cpu_wr_addr;
        bus.mem_wdata    = bus.cpu_wr_data;
        bus.cpu_wr_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Scan sequencing and the one-deep read-return stage with its epoch flag.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      scan_state  <= SCAN_IDLE;
      scan_addr   <= '0;
      rd_vld_p1   <= 1'b0;
      rd_stale_p1 <= 1'b0;
    end else begin
      rd_vld_p1   <= gnt == GNT_RD;
      rd_stale_p1 <= frame_start;
      if (frame_start) begin
        scan_state <= SCAN_FETCH;
        scan_addr  <= '0;
      end else if (gnt == GNT_RD) begin
        if (last_addr) scan_state <= SCAN_IDLE;
        else           scan_addr  <= scan_addr + ADDR_W'(1);
      end
    end
  end

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (bus.mem_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: RAM model plus a queue-based reference of the
// scanout/write sharing rules, checked every cycle.
module tb_fb_access_arbiter;
  import fb_arb_pkg::*;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 9;
  localparam int FB_WORDS   = 19200;
  localparam int FIFO_DEPTH = 4;
  localparam int HIGH_WM    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              pix_pop;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              underrun;
  logic              scan_busy;

  fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH), .HIGH_WM(HIGH_WM)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_valid(pix_valid), .pix_data(pix_data), .underrun(underrun),
    .scan_busy(scan_busy), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pattern(input int a);
    return DATA_W'((a * 37 + 5) % 512);
  endfunction

  // Frame-buffer RAM: unwritten words read back as a per-address pattern.
  logic [DATA_W-1:0] ram_val [FB_WORDS];
  bit                ram_wr  [FB_WORDS];
  always @(posedge clk) begin
    if (bus.mem_en && int'(bus.mem_addr) < FB_WORDS) begin
      if (bus.mem_we) begin
        ram_val[bus.mem_addr] <= bus.mem_wdata;
        ram_wr[bus.mem_addr]  <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram_val[bus.mem_addr] : pattern(int'(bus.mem_addr));
      end
    end
  end

  // Reference state
  logic [DATA_W-1:0] q[$];
  bit                m_fetch, m_infl, m_stale;
  int                m_cnt;
  logic [DATA_W-1:0] m_infl_data;
  logic [DATA_W-1:0] m_mem [FB_WORDS];
  bit                m_wr  [FB_WORDS];
  int                last_g;
  int                delivered;

  // Observations of the last stepped cycle
  logic obs_en, obs_we, obs_ready, obs_valid, obs_under, obs_busy;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_data, obs_wdata;
  int obs_rd_cnt, obs_wr_cnt;

  int errors = 0;
  int checks = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return after the rising edge.
  task automatic step();
    int lvl, g, e_addr, e_wdata;
    bit rd_ok;
    @(negedge clk);
    lvl   = q.size() + int'(m_infl);
    rd_ok = m_fetch && lvl < FIFO_DEPTH;
    if (rst)                        g = 0;
    else if (rd_ok && lvl < HIGH_WM) g = 1;
    else if (bus.cpu_wr_valid)       g = 2;
    else if (rd_ok)                  g = 1;
    else                             g = 0;
    e_addr  = (g == 1) ? m_cnt : (g == 2) ? int'(bus.cpu_wr_addr) : 0;
    e_wdata = (g == 2) ? int'(bus.cpu_wr_data) : 0;

    obs_en = bus.mem_en; obs_we = bus.mem_we; obs_ready = bus.cpu_wr_ready;
    obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata;
    obs_valid = pix_valid; obs_data = pix_data; obs_under = underrun; obs_busy = scan_busy;
    if (obs_en && !obs_we) obs_rd_cnt++;
    if (obs_ready) obs_wr_cnt++;

    chk_eq("mem_en", obs_en, g != 0);
    chk_eq("mem_we", obs_we, g == 2);
    chk_eq("cpu_wr_ready", obs_ready, g == 2);
    chk_eq("mem_addr", obs_addr, e_addr);
    chk_eq("mem_wdata", obs_wdata, e_wdata);
    chk_eq("pix_valid", obs_valid, q.size() > 0);
    chk_eq("pix_data", obs_data, (q.size() > 0) ? q[0] : '0);
    chk_eq("underrun", obs_under, pix_pop && q.size() == 0);
    chk_eq("scan_busy", obs_busy, m_fetch);

    if (rst) begin
      q.delete(); m_fetch = 0; m_cnt = 0; m_infl = 0; m_stale = 0;
    end else begin
      if (pix_pop && q.size() > 0) begin
        void'(q.pop_front());
        delivered++;
      end
      if (frame_start) q.delete();
      else if (m_infl && !m_stale) q.push_back(m_infl_data);
      if (g == 1) m_infl_data = m_wr[m_cnt] ? m_mem[m_cnt] : pattern(m_cnt);
      if (g == 2) begin
        m_mem[bus.cpu_wr_addr] = bus.cpu_wr_data;
        m_wr[bus.cpu_wr_addr]  = 1'b1;
      end
      m_infl  = (g == 1);
      m_stale = frame_start;
      if (frame_start) begin
        m_fetch = 1; m_cnt = 0;
      end else if (g == 1) begin
        if (m_cnt == FB_WORDS - 1) m_fetch = 0;
        else m_cnt++;
      end
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  // Processor write source: holds a request stable until it is granted.
  task automatic drive_wr(input bit want);
    if (bus.cpu_wr_valid && last_g == 2) bus.cpu_wr_valid = 1'b0;
    if (!bus.cpu_wr_valid && want) begin
      bus.cpu_wr_valid = 1'b1;
      bus.cpu_wr_addr  = ADDR_W'($urandom_range(0, FB_WORDS - 1));
      bus.cpu_wr_data  = DATA_W'($urandom);
    end
  endtask

  initial begin
    int cyc, diff;
    logic [DATA_W-1:0] a_val, b_val;
    rst = 1'b1; frame_start = 1'b0; pix_pop = 1'b0;
    bus.cpu_wr_valid = 1'b0; bus.cpu_wr_addr = '0; bus.cpu_wr_data = '0;
    m_fetch = 0; m_infl = 0; m_stale = 0; m_cnt = 0; last_g = 0; delivered = 0;
    obs_rd_cnt = 0; obs_wr_cnt = 0;
    @(posedge clk); #1;

    // Reset values
    step(); step();
    chk_eq("rst_pix_valid", obs_valid, 0);
    chk_eq("rst_pix_data", obs_data, 0);
    chk_eq("rst_scan_busy", obs_busy, 0);
    chk_eq("rst_mem_en", obs_en, 0);
    chk_eq("rst_mem_addr", obs_addr, 0);
    chk_eq("rst_underrun", obs_under, 0);
    rst = 1'b0;
    step();

    // Prefetch fills the FIFO with words 0..3 and stops
    obs_rd_cnt = 0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk_eq("fill_reads", obs_rd_cnt, 4);
    chk_eq("fill_valid", obs_valid, 1);
    chk_eq("fill_head", obs_data, pattern(0));

    // Full FIFO: ten back-to-back writes, no reads
    obs_rd_cnt = 0; obs_wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin drive_wr(1); step(); end
    chk_eq("burst_writes", obs_wr_cnt, 10);
    chk_eq("burst_reads", obs_rd_cnt, 0);
    drive_wr(0);

    // Pop every cycle against a continuous write stream
    pix_pop = 1'b1;
    for (int i = 0; i < 40; i++) begin drive_wr(1); step(); end
    pix_pop = 1'b0;

    // frame_start the cycle after a read issue: stale return dropped, restart at 0
    frame_start = 1'b1; drive_wr(0); step();
    frame_start = 1'b0; drive_wr(0); step();
    chk_eq("restart_rd1_addr", obs_addr, 0);
    frame_start = 1'b1; drive_wr(0); step();
    frame_start = 1'b0; drive_wr(0); step();
    chk_eq("discard_empty", obs_valid, 0);
    chk_eq("restart_rd2_en", obs_en && !obs_we, 1);
    chk_eq("restart_rd2_addr", obs_addr, 0);
    for (int i = 0; i < 4; i++) begin drive_wr(0); step(); end

    // Pop into an empty FIFO right after frame_start
    frame_start = 1'b1; drive_wr(0); step(); frame_start = 1'b0;
    pix_pop = 1'b1; drive_wr(0); step();
    chk_eq("underrun_pulse", obs_under, 1);
    pix_pop = 1'b0; drive_wr(0); step();
    chk_eq("underrun_clear", obs_under, 0);
    for (int i = 0; i < 4; i++) begin drive_wr(0); step(); end

    // Whole frame, pop every 4th cycle, random writes
    frame_start = 1'b1; drive_wr(0); step(); frame_start = 1'b0;
    delivered = 0;
    cyc = 0;
    while (delivered < FB_WORDS && cyc < 80000) begin
      pix_pop = (cyc % 4 == 3);
      drive_wr($urandom_range(0, 2) == 0);
      step();
      cyc++;
    end
    pix_pop = 1'b0;
    chk_eq("frame_delivered", delivered, FB_WORDS);
    chk_eq("frame_busy_low", obs_busy, 0);
    cyc = 0;
    while (bus.cpu_wr_valid && cyc < 20) begin drive_wr(0); step(); cyc++; end
    drive_wr(0);
    chk_eq("writes_drained", bus.cpu_wr_valid, 0);
    step();
    diff = 0;
    for (int a = 0; a < FB_WORDS; a++) begin
      a_val = ram_wr[a] ? ram_val[a] : pattern(a);
      b_val = m_wr[a] ? m_mem[a] : pattern(a);
      if (a_val !== b_val) diff++;
    end
    chk_eq("ram_contents", diff, 0);

    // Reset in the middle of a frame aborts it
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); step(); rst = 1'b0;
    step();
    chk_eq("abort_busy", obs_busy, 0);
    chk_eq("abort_valid", obs_valid, 0);
    chk_eq("abort_mem_en", obs_en, 0);
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
